// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter: two-port (A/B) 32-bit word access arbiter in front of a byte-wide memory.
// Each grant runs four big-endian byte beats, then pulses the winner's ack for one cycle.
`default_nettype none

module mips_mem_arbiter #(
    parameter int ADDR_W    = 10,
    parameter int PRIO_MODE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [31:0]       a_addr,
    input  logic [31:0]       a_wdata,
    output logic [31:0]       a_rdata,
    output logic              a_ack,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [31:0]       b_addr,
    input  logic [31:0]       b_wdata,
    output logic [31:0]       b_rdata,
    output logic              b_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic              busy,
    output logic              owner
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] XFER = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]        state;
    logic [1:0]        beat;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [31:0]       lat_wdata;
    logic              last_grant;
    logic              grant_b;
    logic              unused_addr_hi;

    // Only the low ADDR_W address bits reach the memory.
    assign unused_addr_hi = ^{a_addr[31:ADDR_W], b_addr[31:ADDR_W]};

    function automatic logic [7:0] pick_byte(input logic [31:0] word, input logic [1:0] k);
        case (k)
            2'd0: pick_byte = word[31:24];
            2'd1: pick_byte = word[23:16];
            2'd2: pick_byte = word[15:8];
            2'd3: pick_byte = word[7:0];
        endcase
    endfunction

    function automatic logic [31:0] put_byte(input logic [31:0] word, input logic [1:0] k,
                                             input logic [7:0] val);
        put_byte = word;
        case (k)
            2'd0: put_byte[31:24] = val;
            2'd1: put_byte[23:16] = val;
            2'd2: put_byte[15:8]  = val;
            2'd3: put_byte[7:0]   = val;
        endcase
    endfunction

    // On a tie, round-robin favours whichever port lost the previous grant.
    always_comb begin
        if (a_req && b_req) begin
            grant_b = (PRIO_MODE == 0) ? ~last_grant : 1'b0;
        end else begin
            grant_b = b_req;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            beat       <= 2'd0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= 32'd0;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            a_rdata    <= 32'd0;
            b_rdata    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (a_req || b_req) begin
                        state      <= XFER;
                        beat       <= 2'd0;
                        owner      <= grant_b;
                        last_grant <= grant_b;
                        lat_we     <= grant_b ? b_we : a_we;
                        lat_addr   <= grant_b ? b_addr[ADDR_W-1:0] : a_addr[ADDR_W-1:0];
                        lat_wdata  <= grant_b ? b_wdata : a_wdata;
                    end
                end
                XFER: begin
                    if (!lat_we) begin
                        if (owner) begin
                            b_rdata <= put_byte(b_rdata, beat, mem_rdata);
                        end else begin
                            a_rdata <= put_byte(a_rdata, beat, mem_rdata);
                        end
                    end
                    beat <= beat + 2'd1;
                    if (beat == 2'd3) begin
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Memory strobes decode straight from state so reset silences them without a clock.
    always_comb begin
        busy      = (state != IDLE);
        a_ack     = (state == DONE) && !owner;
        b_ack     = (state == DONE) && owner;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = 8'd0;
        if (state == XFER) begin
            mem_addr  = lat_addr + ADDR_W'(beat);
            mem_read  = !lat_we;
            mem_write = lat_we;
            if (lat_we) begin
                mem_wdata = pick_byte(lat_wdata, beat);
            end
        end
    end

endmodule

`default_nettype wire
